// File: rtl/instruction_fetch_unit.sv
// Purpose : IF stage of the pipelined MIPS CPU. Owns the PC, drives the
//           combinational instruction memory and fills the IF/ID register.
// Latency : 1 clk. The word at PC appears on IF/ID at the next rising edge.
// Backpres: stall holds the PC and IF/ID. flush or redirect inserts a bubble.
//           A redirect overrides stall. A detected halt freezes everything
//           until reset.
//
// Optional feature macro: HALT_DETECT_EN (jump-to-self halt detection).
//
// Ports:
//   clk, reset_n    rising-edge clock, asynchronous active-low reset
//   stall           hold the PC and IF/ID this cycle
//   flush           kill the instruction entering IF/ID
//   redirect_valid  load redirect_pc (word aligned) into the PC next edge
//   redirect_pc     redirect target, bits [1:0] ignored
//   imem_addr       instruction memory address, always equal to the PC
//   imem_instr      instruction word returned combinationally by memory
//   ifid_instr      IF/ID instruction word
//   ifid_pc_plus4   IF/ID PC+4 of that instruction
//   ifid_valid      IF/ID holds a real instruction (0 = bubble)
//   halted          jump-to-self halt seen (tied 0 without HALT_DETECT_EN)

module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc_plus4,
   output logic        ifid_valid,
   output logic        halted
);

   localparam logic [5:0] OPC_J = 6'b000010;

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_aligned;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        halted_q;
   logic        capture;
   logic        halt_hit;

   // Wraps modulo 2^32, so 0xFFFF_FFFC rolls over to 0.
   assign pc_plus4         = pc_q + 32'd4;
   assign redirect_aligned = redirect_pc & ~32'h0000_0003;
   assign imem_addr        = pc_q;

   // A fresh word is latched into IF/ID only when no bubble, stall or halt applies.
   assign capture = !(flush || redirect_valid) && !stall && !halted_q;

`ifdef HALT_DETECT_EN
   logic halted_d;

   // Jump-to-self: J opcode whose low target bits address the current word.
   // Only the low 8 target bits are compared because memory holds 256 words.
   assign halt_hit = capture
                     && (imem_instr[31:26] == OPC_J)
                     && (imem_instr[7:0] == pc_q[9:2]);
   assign halted_d = halted_q | halt_hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end
`else
   assign halt_hit = 1'b0;
   assign halted_q = 1'b0;
`endif

   assign halted = halted_q;

   // PC next state. The edge that detects a halt also holds the PC.
   // The halting word therefore stays on imem_addr.
   always_comb begin
      pc_d = pc_q;
      if (halted_q || halt_hit) begin
         pc_d = pc_q;
      end else if (redirect_valid) begin
         pc_d = redirect_aligned;
      end else if (stall) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_plus4;
      end
   end

   // IF/ID next state. A halt takes precedence over flush and redirect.
   // Once halted, the pipeline register is frozen.
   always_comb begin
      ifid_instr_d    = ifid_instr_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      ifid_valid_d    = ifid_valid_q;
      if (halted_q) begin
         ifid_instr_d    = ifid_instr_q;
         ifid_pc_plus4_d = ifid_pc_plus4_q;
         ifid_valid_d    = ifid_valid_q;
      end else if (flush || redirect_valid) begin
         ifid_instr_d    = 32'h0;
         ifid_pc_plus4_d = 32'h0;
         ifid_valid_d    = 1'b0;
      end else if (stall) begin
         ifid_instr_d    = ifid_instr_q;
         ifid_pc_plus4_d = ifid_pc_plus4_q;
         ifid_valid_d    = ifid_valid_q;
      end else begin
         ifid_instr_d    = imem_instr;
         ifid_pc_plus4_d = pc_plus4;
         ifid_valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q            <= RESET_PC;
         ifid_instr_q    <= 32'h0;
         ifid_pc_plus4_q <= 32'h0;
         ifid_valid_q    <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         ifid_instr_q    <= ifid_instr_d;
         ifid_pc_plus4_q <= ifid_pc_plus4_d;
         ifid_valid_q    <= ifid_valid_d;
      end
   end

   assign ifid_instr    = ifid_instr_q;
   assign ifid_pc_plus4 = ifid_pc_plus4_q;
   assign ifid_valid    = ifid_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 256-word combinational
// instruction memory model. Word i holds 0x2004_0000 + i.
// Addresses outside the 256-word memory read as 0.

module tb_instruction_fetch_unit;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_valid;
   logic        halted;

   logic [31:0] mem [0:255];
   int checks;
   int errors;

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .ifid_instr     (ifid_instr),
      .ifid_pc_plus4  (ifid_pc_plus4),
      .ifid_valid     (ifid_valid),
      .halted         (halted)
   );

   assign imem_instr = (imem_addr[31:10] == 22'h0) ? mem[imem_addr[9:2]] : 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then sample and drive 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] pc,
                             input logic [31:0] instr, input logic [31:0] pc4,
                             input logic vld);
      check({tag, ".pc"},    imem_addr,     pc);
      check({tag, ".instr"}, ifid_instr,    instr);
      check({tag, ".pc4"},   ifid_pc_plus4, pc4);
      check({tag, ".vld"},   {31'h0, ifid_valid}, {31'h0, vld});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h2004_0000 + i;
      mem[11] = 32'h0810_000b;

      reset_n        = 1'b0;
      stall          = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      // Reset state.
      #2;
      check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      check("reset.halted", {31'h0, halted}, 32'h0);
      #6 reset_n = 1'b1;

      // First fetches from address 0, then address 4.
      step();
      check_ifid("fetch0", 32'h4, 32'h2004_0000, 32'h4, 1'b1);
      step();
      check_ifid("fetch1", 32'h8, 32'h2004_0001, 32'h8, 1'b1);

      // A flush on its own makes a bubble while the PC still advances.
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_ifid("flush", 32'hC, 32'h0, 32'h0, 1'b0);
      step();
      check_ifid("post_flush", 32'h10, 32'h2004_0003, 32'h10, 1'b1);

      // Stall for three cycles at pc 0x10.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_ifid($sformatf("stall%0d", i), 32'h10, 32'h2004_0003, 32'h10, 1'b1);
      end
      stall = 1'b0;
      step();
      check_ifid("stall_rel", 32'h14, 32'h2004_0004, 32'h14, 1'b1);

      // Stall with flush: the PC holds and a bubble is inserted.
      stall = 1'b1;
      flush = 1'b1;
      step();
      stall = 1'b0;
      flush = 1'b0;
      check_ifid("stall_flush", 32'h14, 32'h0, 32'h0, 1'b0);
      step();
      check_ifid("sf_rel", 32'h18, 32'h2004_0005, 32'h18, 1'b1);

      // Redirect at pc 0x20 with stall also high. The target is misaligned.
      step();
      step();
      check_ifid("at20", 32'h20, 32'h2004_0007, 32'h20, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_000E;
      stall          = 1'b1;
      step();
      redirect_valid = 1'b0;
      stall          = 1'b0;
      check_ifid("redirect", 32'hC, 32'h0, 32'h0, 1'b0);
      step();
      check_ifid("post_redir", 32'h10, 32'h2004_0003, 32'h10, 1'b1);

      // The PC wraps from 0xFFFF_FFFC. An out-of-range fetch gives a valid nop.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      check_ifid("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
      step();
      check_ifid("wrap", 32'h0, 32'h0, 32'h0, 1'b1);
      step();
      check_ifid("after_wrap", 32'h4, 32'h2004_0000, 32'h4, 1'b1);

      // Jump-to-self word at 0x2C.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_002C;
      step();
      redirect_valid = 1'b0;
      check_ifid("to_2c", 32'h2C, 32'h0, 32'h0, 1'b0);
      step();
`ifdef HALT_DETECT_EN
      check_ifid("halt_edge", 32'h2C, 32'h0810_000b, 32'h30, 1'b1);
      check("halt_edge.halted", {31'h0, halted}, 32'h1);
      // After a halt, flush and redirect have no effect.
      for (int i = 0; i < 10; i++) begin
         flush          = (i % 2) == 0;
         redirect_valid = (i % 3) == 0;
         redirect_pc    = 32'h0000_0040;
         stall          = (i % 4) == 1;
         step();
         check_ifid($sformatf("halt%0d", i), 32'h2C, 32'h0810_000b, 32'h30, 1'b1);
         check($sformatf("halt%0d.halted", i), {31'h0, halted}, 32'h1);
      end
      flush          = 1'b0;
      redirect_valid = 1'b0;
      stall          = 1'b0;
`else
      check_ifid("nohalt_edge", 32'h30, 32'h0810_000b, 32'h30, 1'b1);
      check("nohalt.halted", {31'h0, halted}, 32'h0);
      step();
      check_ifid("nohalt_next", 32'h34, 32'h2004_000c, 32'h34, 1'b1);
      check("nohalt_next.halted", {31'h0, halted}, 32'h0);
`endif

      // An asynchronous reset mid-run clears state without a clock edge.
      reset_n = 1'b0;
      #2;
      check_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
      check("async_rst.halted", {31'h0, halted}, 32'h0);
      #3 reset_n = 1'b1;
      step();
      check_ifid("rst_refetch", 32'h4, 32'h2004_0000, 32'h4, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
